// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: start-bit validation, mid-bit sampling, optional parity,
// 1-2 stop bits, line-break tracking and a single-entry valid/ready output register.
module uart_rx_os #(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY_MODE  = 1,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned CLKS_PER_BIT = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 ready,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BitW = 4;
  localparam logic [CntW-1:0] CntHalf  = CntW'(CLKS_PER_BIT / 2);
  localparam logic [CntW-1:0] CntLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [BitW-1:0] DataLast = BitW'(DATA_BITS - 1);
  localparam logic [BitW-1:0] StopLast = BitW'(STOP_BITS - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StBreak} state_e;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [BitW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic                   par_q, par_d;
  logic                   ferr_q, ferr_d;
  logic                   rx_meta, rxs;
  logic                   armed_q;
  logic                   done;
  logic                   done_perr;

  // Synchronizer flops reset high so an idle line is not mistaken for a start bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      armed_q <= 1'b0;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
      armed_q <= armed_q | rxs;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    ferr_d  = ferr_q;
    done    = 1'b0;
    case (state_q)
      StIdle: begin
        cnt_d = '0;
        bit_d = '0;
        if (armed_q && !rxs) begin
          state_d = StStart;
          ferr_d  = 1'b0;
          par_d   = 1'b0;
        end
      end
      StStart: begin
        if (cnt_q == CntHalf) begin
          cnt_d   = '0;
          state_d = rxs ? StIdle : StData;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StData: begin
        if (cnt_q == CntLast) begin
          cnt_d   = '0;
          shreg_d = {rxs, shreg_q[DATA_BITS-1:1]};
          if (bit_q == DataLast) begin
            bit_d   = '0;
            state_d = (PARITY_MODE == 0) ? StStop : StParity;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StParity: begin
        if (cnt_q == CntLast) begin
          cnt_d   = '0;
          par_d   = rxs;
          state_d = StStop;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StStop: begin
        if (cnt_q == CntLast) begin
          cnt_d = '0;
          if (!rxs) ferr_d = 1'b1;
          if (bit_q == StopLast) begin
            bit_d   = '0;
            done    = 1'b1;
            state_d = rxs ? StIdle : StBreak;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StBreak: begin
        cnt_d = '0;
        if (rxs) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    done_perr = 1'b0;
    if (PARITY_MODE == 1) done_perr = ^{shreg_q, par_q};
    else if (PARITY_MODE == 2) done_perr = ~^{shreg_q, par_q};
  end

  // Completed frames load only into an empty or draining register; otherwise they are dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data       <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (done) begin
        if (!valid || ready) begin
          valid      <= 1'b1;
          data       <= shreg_q;
          parity_err <= done_perr;
          frame_err  <= ferr_d;
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

  assign busy = (state_q != StIdle);

endmodule
